// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the streaming multiply-accumulate stage.
package mult_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } mac_state_t;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = 255;

  // Default accumulator width: full product plus 8 bits of headroom.
  function automatic int unsigned acc_size_f(input int unsigned size);
    return 2 * size + 8;
  endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational unsigned multiplier producing the full-width product.
module multiplier #(
  parameter int unsigned SIZE = 8
) (
  input  logic [SIZE-1:0]   in_a,
  input  logic [SIZE-1:0]   in_b,
  output logic [2*SIZE-1:0] out_prod
);

  localparam int unsigned PROD_W = 2 * SIZE;

  assign out_prod = PROD_W'(in_a) * PROD_W'(in_b);

endmodule

// File: rtl/mult_accumulator.sv
// Streaming MAC: registers operand beats, sums products per group and
// presents each group total on a valid/ready output.
module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter int unsigned SIZE     = 8,
  parameter int unsigned ACC_SIZE = acc_size_f(SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE-1:0]     in_a,
  input  logic [SIZE-1:0]     in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_SIZE-1:0] out_acc,
  output logic                out_ovf,
  output logic [CNT_W-1:0]    out_count
);

  localparam int unsigned PROD_W = 2 * SIZE;
  localparam int unsigned SUM_W  = ACC_SIZE + 1;

  logic                r_op_valid;
  logic [SIZE-1:0]     r_op_a;
  logic [SIZE-1:0]     r_op_b;
  logic                r_op_last;
  mac_state_t          r_state;
  logic [ACC_SIZE-1:0] r_acc;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_count;

  logic [PROD_W-1:0]   w_prod;
  logic [SUM_W-1:0]    w_sum;
  logic                w_accept;

  // While DONE the operand stage can absorb exactly one beat, then stalls.
  assign in_ready = !r_op_valid || (r_state == ACCUM);
  assign w_accept = in_valid && in_ready;

  multiplier #(
    .SIZE (SIZE)
  ) u_multiplier (
    .in_a     (r_op_a),
    .in_b     (r_op_b),
    .out_prod (w_prod)
  );

  // Extra top bit captures the carry out of the accumulator width.
  assign w_sum = {1'b0, r_acc} + SUM_W'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_valid <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_last  <= 1'b0;
    end else if (w_accept) begin
      r_op_valid <= 1'b1;
      r_op_a     <= in_a;
      r_op_b     <= in_b;
      r_op_last  <= in_last;
    end else if (r_op_valid && (r_state == ACCUM)) begin
      r_op_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (r_op_valid) begin
            r_acc <= w_sum[ACC_SIZE-1:0];
            r_ovf <= r_ovf | w_sum[ACC_SIZE];
            if (r_count != CNT_W'(CNT_MAX)) begin
              r_count <= r_count + CNT_W'(1);
            end
            if (r_op_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_state <= ACCUM;
          end
        end
      endcase
    end
  end

  assign out_valid = (r_state == DONE);
  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;
  assign out_count = r_count;

endmodule

// File: tb/tb_mult_accumulator.sv
// Scoreboard bench for mult_accumulator: directed scenarios plus random groups
// checked against an arithmetic sum-of-products model.
module tb_mult_accumulator;

  localparam int unsigned SIZE     = 8;
  localparam int unsigned ACC_SIZE = 24;

  typedef struct {
    longint unsigned acc;
    longint unsigned ovf;
    longint unsigned cnt;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [SIZE-1:0]     in_a;
  logic [SIZE-1:0]     in_b;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_SIZE-1:0] out_acc;
  logic                out_ovf;
  logic [7:0]          out_count;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];
  longint unsigned m_sum = 0;
  int              m_n   = 0;

  bit hold_out  = 1'b0;
  bit rand_out  = 1'b0;

  mult_accumulator #(
    .SIZE     (SIZE),
    .ACC_SIZE (ACC_SIZE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream readiness: forced low, random, or always ready.
  always @(posedge clk) begin
    #1;
    if (hold_out)      out_ready = 1'b0;
    else if (rand_out) out_ready = 1'($urandom_range(0, 1));
    else               out_ready = 1'b1;
  end

  // Monitor: pop on each output transfer, and keep stalled results stable.
  bit              stalled = 1'b0;
  longint unsigned st_acc, st_ovf, st_cnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("valid_held", out_valid, 1);
        if (out_valid) begin
          chk("acc_stable", out_acc, st_acc);
          chk("ovf_stable", out_ovf, st_ovf);
          chk("cnt_stable", out_count, st_cnt);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_acc", out_acc, e.acc);
          chk("out_ovf", out_ovf, e.ovf);
          chk("out_count", out_count, e.cnt);
        end
      end
      stalled = out_valid && !out_ready;
      st_acc  = out_acc;
      st_ovf  = out_ovf;
      st_cnt  = out_count;
    end
  end

  // Issue one beat; returns number of cycles it waited for in_ready.
  task automatic send_beat(input int a, input int b, input bit last, output int stalls);
    int waited = 0;
    in_valid = 1'b1;
    in_a     = SIZE'(a);
    in_b     = SIZE'(b);
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      m_sum += longint'(a) * longint'(b);
      m_n++;
      if (last) begin
        exp_t e;
        e.acc = m_sum % (64'd1 << ACC_SIZE);
        e.ovf = (m_sum >= (64'd1 << ACC_SIZE)) ? 1 : 0;
        e.cnt = (m_n > 255) ? 255 : m_n;
        exp_q.push_back(e);
        m_sum = 0;
        m_n   = 0;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    stalls   = waited;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_pending", exp_q.size(), 0);
    align();
  endtask

  initial begin
    int st;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_in_ready", in_ready, 1);
    align();
    rst_n = 1'b1;
    align();

    // 1: single beat and its 2-cycle latency
    send_beat(3, 5, 1, st);
    @(negedge clk);
    chk("lat_early", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    align();

    // 2: three back-to-back beats, never stalled
    for (int i = 0; i < 3; i++) begin
      send_beat(255, 255, i == 2, st);
      chk("b2b_stall", st, 0);
    end
    drain();

    // 3: overflow wrap and count saturation
    for (int i = 0; i < 259; i++) send_beat(255, 255, i == 258, st);
    drain();

    // 4: backpressure with a beat parked in the operand stage
    hold_out = 1'b1;
    send_beat(5, 6, 1, st);
    send_beat(2, 7, 1, st);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    hold_out = 1'b0;
    drain();

    // 5: reset mid-group discards partial state
    send_beat(4, 4, 0, st);
    @(negedge clk);
    rst_n = 1'b0;
    m_sum = 0;
    m_n   = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_acc", out_acc, 0);
    chk("mid_rst_ovf", out_ovf, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_ready", in_ready, 1);
    align();
    rst_n = 1'b1;
    align();
    send_beat(1, 9, 1, st);
    drain();

    // 6: zero operands still count
    send_beat(0, 200, 0, st);
    send_beat(17, 0, 0, st);
    send_beat(1, 1, 1, st);
    drain();

    // Random groups with random gaps and random downstream readiness
    rand_out = 1'b1;
    for (int g = 0; g < 25; g++) begin
      int len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) align();
        send_beat($urandom_range(0, 255), $urandom_range(0, 255), i == len - 1, st);
      end
    end
    rand_out = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Streaming multiply-accumulate stage built around the existing combinational `multiplier`. Operand pairs arrive on a valid/ready stream and are registered, then multiplied. Products are summed into a wide accumulator until a beat flagged `in_last` is consumed. The group total is then presented on a valid/ready output to the downstream ALU result path.

## Interface
- `SIZE`, default 8: operand width; passed to `multiplier`.
- `ACC_SIZE`, default 2*SIZE+8: accumulator width; must be at least 2*SIZE.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_a` in SIZE: multiplicand, unsigned.
- `in_b` in SIZE: multiplier, unsigned.
- `in_last` in 1: beat closes the current group.
- `out_valid` out 1: group result available.
- `out_ready` in 1: downstream accepts the result.
- `out_acc` out ACC_SIZE: group sum, modulo 2^ACC_SIZE.
- `out_ovf` out 1: sticky flag; a carry out of ACC_SIZE occurred in this group.
- `out_count` out 8: beats in the group, saturating at 255.

## Operation
- **Operand stage:** registers `op_valid`, `op_a`, `op_b`, `op_last`.
  - A beat is accepted on a rising edge with `in_valid && in_ready`.
  - `in_ready = !op_valid || (state == ACCUM)`, which is combinational.
  - If a beat is accepted, the registers load it. Otherwise, if `op_valid` and `state == ACCUM`, `op_valid` clears. Otherwise the registers hold.
- **Product:** `prod = multiplier(op_a, op_b)`, 2*SIZE bits, zero-extended to ACC_SIZE+1 for the add.
- **FSM states:** ACCUM and DONE.
  - **ACCUM, when `op_valid`:**
    - `acc <= (acc + prod)[ACC_SIZE-1:0]`.
    - `ovf <= ovf | carry`.
    - `count <= min(count+1, 255)`.
    - If `op_last`, go to DONE.
  - **ACCUM, when `op_valid` is low:** nothing changes.
  - **DONE:**
    - `out_valid = 1`; `out_acc`, `out_ovf` and `out_count` are driven from the registers and held stable.
    - The operand stage may fill one beat, then stalls (`in_ready = 0` while `op_valid`).
    - On `out_ready`, clear `acc`, `ovf` and `count` to 0 and go to ACCUM.
- `out_valid` is asserted only in DONE.
- **Boundary cases:**
  - **Single-beat group** (`in_last` on the first beat): legal; `count = 1`.
  - **Zero operand:** the beat still increments `count`.
  - **Overflow wrap:** `acc` wraps; `ovf` stays set until the result is taken.
  - **Beat held in the operand stage at DONE exit:** accumulates into the fresh group in the first ACCUM cycle.
  - **Reset mid-group:** discards all partial state; there is no partial output.

## Timing
- **Reset values:**
  - state = ACCUM; `op_valid`, `acc`, `ovf`, `count` = 0.
  - Outputs: `out_valid = 0`, `out_acc = 0`, `out_ovf = 0`, `out_count = 0`, `in_ready = 1`.
- **Throughput:** one beat per cycle while in ACCUM.
- **Latency:** last beat accepted at edge k, accumulated at edge k+1, `out_valid` high in the cycle after edge k+1, i.e. 2 cycles.
- **Group turnaround:** exactly one cycle with `in_ready = 0`, when the operand stage is full during DONE and `out_ready` arrives. The handoff edge leaves DONE and the next edge accumulates the held beat.
- **Output handshake:** transfers on the edge where `out_valid && out_ready`. `out_valid` must not drop before that edge.
- The multiplier path is combinational between operand registers and accumulator; there is no internal multiplier pipelining.

## Structure
- Package `mult_acc_pkg`:
  - state enum `mac_state_t {ACCUM, DONE}`.
  - `localparam CNT_W = 8`, `CNT_MAX = 255`.
  - default-width helper `acc_size_f(SIZE)`.
- One sub-module instance: the existing `multiplier`, with `SIZE` passed through.
- Everything else is inline: operand register, FSM, accumulator.

## Test plan
All scenarios use SIZE=8, ACC_SIZE=24.
1. **Single beat:** a=3, b=5, last=1 accepted at edge k -> `out_valid` after edge k+1; `out_acc = 15`, `out_count = 1`, `out_ovf = 0`.
2. **Three back-to-back beats:** a=b=255, last on the third -> `out_acc = 195075`, `out_count = 3`, `out_ovf = 0`; `in_ready` high throughout.
3. **Overflow and saturation:** 259 beats of a=b=255 -> `out_acc = 64259`, `out_ovf = 1`, `out_count = 255`.
4. **Backpressure:** `out_ready` low for 10 cycles with `in_valid` held.
   - `in_ready` drops once the operand stage is full.
   - `out_acc` stays stable.
   - After release, the next group {a=2, b=7, last} gives `out_acc = 14` with no carry-over.
5. **Reset mid-group:** {4×4} accepted, `rst_n` pulsed low -> all outputs 0, `in_ready = 1`. Subsequent {1×9, last} gives `out_acc = 9`, `out_count = 1`.
6. **Zero operands:** {0×200, 17×0, 1×1 last} -> `out_acc = 1`, `out_count = 3`.
